// File: rtl/uart_core_if.sv
// Register-file side of the UART: transmit request/status and received byte.
// The core takes the slave view; the bus-side register block takes master.
interface uart_core_if;
    logic [7:0] tx_data;
    logic       tx_en;
    logic       tx_status;
    logic [7:0] rx_data;
    logic       rx_status;

    modport master (
        output tx_data,
        output tx_en,
        input  tx_status,
        input  rx_data,
        input  rx_status
    );

    modport slave (
        input  tx_data,
        input  tx_en,
        output tx_status,
        output rx_data,
        output rx_status
    );
endinterface

// File: rtl/uart_core.sv
// 8N1 UART: free-running 16x tick enable, buffered transmitter and
// mid-bit oversampling receiver sharing one clock domain.
module uart_core #(
    parameter int CLKS_PER_TICK = 651
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic       tx,
    output logic       baud_tick,
    uart_core_if.slave bus
);
    localparam int CW = (CLKS_PER_TICK > 1) ? $clog2(CLKS_PER_TICK) : 1;
    localparam logic [CW-1:0] CMAX = CW'(CLKS_PER_TICK - 1);

    typedef enum logic [2:0] {
        T_IDLE, T_WAIT, T_START, T_DATA, T_STOP
    } tx_state_t;

    typedef enum logic [1:0] {
        R_IDLE, R_START, R_DATA, R_STOP
    } rx_state_t;

    logic [CW-1:0] cnt;

    tx_state_t tx_state, tx_state_n;
    logic [3:0] tx_phase, tx_phase_n;
    logic [3:0] tx_bit, tx_bit_n;
    logic [7:0] tx_shift, tx_shift_n;
    logic       tx_n;
    logic       tx_last;

    rx_state_t rx_state, rx_state_n;
    logic [3:0] rx_phase, rx_phase_n;
    logic [3:0] rx_bit, rx_bit_n;
    logic [7:0] rx_shift, rx_shift_n;
    logic       rx_ferr, rx_ferr_n;
    logic [7:0] rx_data_q, rx_data_n;
    logic       rx_status_q, rx_status_n;
    logic       rx_meta, rx_sync, rx_prev;
    logic       rx_full;

    assign baud_tick = (cnt == CMAX);

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt <= '0;
        end else if (baud_tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // Transmitter
    assign tx_last = baud_tick && (tx_phase == 4'd15);
    assign bus.tx_status = (tx_state == T_IDLE);

    always_ff @(posedge clk) begin
        if (!reset) begin
            tx_state <= T_IDLE;
            tx_phase <= '0;
            tx_bit   <= '0;
            tx_shift <= '0;
            tx       <= 1'b1;
        end else begin
            tx_state <= tx_state_n;
            tx_phase <= tx_phase_n;
            tx_bit   <= tx_bit_n;
            tx_shift <= tx_shift_n;
            tx       <= tx_n;
        end
    end

    always_comb begin
        tx_state_n = tx_state;
        tx_phase_n = tx_phase;
        tx_bit_n   = tx_bit;
        tx_shift_n = tx_shift;
        tx_n       = tx;
        if (baud_tick) tx_phase_n = tx_phase + 4'd1;
        unique case (tx_state)
            T_IDLE: begin
                if (bus.tx_en) begin
                    tx_shift_n = bus.tx_data;
                    tx_state_n = T_WAIT;
                end
            end
            T_WAIT: begin
                if (baud_tick) begin
                    tx_state_n = T_START;
                    tx_phase_n = '0;
                    tx_n       = 1'b0;
                end
            end
            T_START: begin
                if (tx_last) begin
                    tx_state_n = T_DATA;
                    tx_bit_n   = '0;
                    tx_n       = tx_shift[0];
                    tx_shift_n = tx_shift >> 1;
                end
            end
            T_DATA: begin
                if (tx_last) begin
                    if (tx_bit == 4'd7) begin
                        tx_state_n = T_STOP;
                        tx_n       = 1'b1;
                    end else begin
                        tx_bit_n   = tx_bit + 4'd1;
                        tx_n       = tx_shift[0];
                        tx_shift_n = tx_shift >> 1;
                    end
                end
            end
            T_STOP: begin
                if (tx_last) tx_state_n = T_IDLE;
            end
            default: tx_state_n = T_IDLE;
        endcase
    end

    // Receiver; rx_prev tracks the synchronized line for start-edge detect
    assign rx_full = baud_tick && (rx_phase == 4'd15);
    assign bus.rx_data   = rx_data_q;
    assign bus.rx_status = rx_status_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            rx_meta     <= 1'b1;
            rx_sync     <= 1'b1;
            rx_prev     <= 1'b1;
            rx_state    <= R_IDLE;
            rx_phase    <= '0;
            rx_bit      <= '0;
            rx_shift    <= '0;
            rx_ferr     <= 1'b0;
            rx_data_q   <= '0;
            rx_status_q <= 1'b0;
        end else begin
            rx_meta     <= rx;
            rx_sync     <= rx_meta;
            rx_prev     <= rx_sync;
            rx_state    <= rx_state_n;
            rx_phase    <= rx_phase_n;
            rx_bit      <= rx_bit_n;
            rx_shift    <= rx_shift_n;
            rx_ferr     <= rx_ferr_n;
            rx_data_q   <= rx_data_n;
            rx_status_q <= rx_status_n;
        end
    end

    always_comb begin
        rx_state_n  = rx_state;
        rx_phase_n  = rx_phase;
        rx_bit_n    = rx_bit;
        rx_shift_n  = rx_shift;
        rx_ferr_n   = rx_ferr;
        rx_data_n   = rx_data_q;
        rx_status_n = 1'b0;
        if (baud_tick) rx_phase_n = rx_phase + 4'd1;
        unique case (rx_state)
            R_IDLE: begin
                if (rx_prev && !rx_sync) begin
                    rx_state_n = R_START;
                    rx_phase_n = '0;
                end
            end
            R_START: begin
                if (baud_tick && rx_phase == 4'd7) begin
                    if (!rx_sync) begin
                        rx_state_n = R_DATA;
                        rx_phase_n = '0;
                        rx_bit_n   = '0;
                    end else begin
                        rx_state_n = R_IDLE;
                    end
                end
            end
            R_DATA: begin
                if (rx_full) begin
                    rx_shift_n = {rx_sync, rx_shift[7:1]};
                    if (rx_bit == 4'd7) begin
                        rx_state_n = R_STOP;
                        rx_ferr_n  = 1'b0;
                    end else begin
                        rx_bit_n = rx_bit + 4'd1;
                    end
                end
            end
            R_STOP: begin
                // After a framing error, hold here until the line idles
                if (rx_ferr) begin
                    if (rx_sync) rx_state_n = R_IDLE;
                end else if (rx_full) begin
                    if (rx_sync) begin
                        rx_data_n   = rx_shift;
                        rx_status_n = 1'b1;
                        rx_state_n  = R_IDLE;
                    end else begin
                        rx_ferr_n = 1'b1;
                    end
                end
            end
            default: rx_state_n = R_IDLE;
        endcase
    end
endmodule

// File: tb/tb_uart_core.sv
// Randomized bench for uart_core: frames are built and decoded from
// bit-period arithmetic and compared against byte queues.
module tb_uart_core;
    logic clk = 1'b0;
    logic reset = 1'b0;
    logic rx_drv = 1'b1;
    logic loop = 1'b0;
    logic rx_line;
    logic tx;
    logic baud_tick;

    int checks = 0;
    int errors = 0;

    logic [7:0] got_q[$];
    logic [7:0] exp_q[$];
    logic [7:0] last_good = 8'h00;

    uart_core_if bus();

    assign rx_line = loop ? tx : rx_drv;

    uart_core #(.CLKS_PER_TICK(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .rx        (rx_line),
        .tx        (tx),
        .baud_tick (baud_tick),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    always @(negedge clk)
        if (bus.rx_status === 1'b1) got_q.push_back(bus.rx_data);

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tx_send(input logic [7:0] b);
        check("tx_ready", bus.tx_status, 1);
        @(posedge clk); #1;
        bus.tx_data = b;
        bus.tx_en = 1'b1;
        @(posedge clk); #1;
        bus.tx_en = 1'b0;
        @(negedge clk);
        check("tx_busy", bus.tx_status, 0);
    endtask

    // Decode the tx line: bit i is sampled 32 + 64*i clks after the start fall
    task automatic tx_capture(input logic [7:0] b);
        logic [9:0] f;
        int k;
        int bi;
        f = {1'b1, b, 1'b0};
        k = 0;
        while (tx !== 1'b0 && k < 16) begin
            @(negedge clk);
            k++;
        end
        check("tx_start", (k < 16), 1);
        if (k >= 16) return;
        k = 0;
        bi = 0;
        while (k < 2000) begin
            if (bi < 10 && k == 32 + 64 * bi) begin
                check($sformatf("tx_bit%0d", bi), tx, f[bi]);
                bi++;
            end
            if (bus.tx_status === 1'b1) break;
            @(negedge clk);
            k++;
        end
        check("tx_frame_len", k, 640);
    endtask

    task automatic send_rx(input logic [7:0] b, input logic stop);
        logic [9:0] f;
        f = {stop, b, 1'b0};
        repeat ($urandom_range(1, 4)) @(posedge clk);
        #1;
        for (int i = 0; i < 10; i++) begin
            rx_drv = f[i];
            repeat (64) @(posedge clk);
            #1;
        end
        rx_drv = 1'b1;
        repeat (64) @(posedge clk);
        #1;
        if (stop) begin
            exp_q.push_back(b);
            last_good = b;
        end
    endtask

    task automatic drain();
        repeat (16) @(negedge clk);
        check("rx_count", got_q.size(), exp_q.size());
        while (got_q.size() > 0 && exp_q.size() > 0)
            check("rx_byte", got_q.pop_front(), exp_q.pop_front());
        got_q.delete();
        exp_q.delete();
        check("rx_data", bus.rx_data, last_good);
    endtask

    task automatic pulse_reset();
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        last_good = 8'h00;
    endtask

    initial begin
        int n_pulse;
        int adj;
        int gap_err;
        int last;
        logic prev;
        logic [7:0] b;
        logic [9:0] f;

        bus.tx_data = 8'h00;
        bus.tx_en = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_tx", tx, 1);
        check("rst_tx_status", bus.tx_status, 1);
        check("rst_rx_status", bus.rx_status, 0);
        check("rst_rx_data", bus.rx_data, 8'h00);
        check("rst_tick", baud_tick, 0);
        @(posedge clk); #1;
        reset = 1'b1;

        n_pulse = 0; adj = 0; gap_err = 0; last = -1; prev = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (baud_tick) begin
                n_pulse++;
                if (prev) adj++;
                if (last >= 0 && i - last != 4) gap_err++;
                last = i;
            end
            prev = baud_tick;
        end
        check("tick_count", n_pulse, 10);
        check("tick_width", adj, 0);
        check("tick_period", gap_err, 0);

        tx_send(8'hA5);
        bus.tx_data = 8'h5A;
        tx_capture(8'hA5);

        send_rx(8'h3C, 1'b1);
        drain();
        send_rx(8'h7E, 1'b0);
        drain();
        send_rx(8'h12, 1'b1);
        drain();

        @(posedge clk); #1;
        rx_drv = 1'b0;
        repeat (16) @(posedge clk);
        #1;
        rx_drv = 1'b1;
        repeat (200) @(posedge clk);
        drain();
        send_rx(8'h55, 1'b1);
        drain();

        loop = 1'b1;
        for (int i = 0; i < 7; i++) begin
            case (i)
                0: b = 8'h00;
                1: b = 8'hFF;
                2: b = 8'h81;
                default: b = 8'($urandom);
            endcase
            tx_send(b);
            bus.tx_data = 8'($urandom);
            exp_q.push_back(b);
            last_good = b;
            tx_capture(b);
        end
        drain();
        loop = 1'b0;
        repeat (20) @(posedge clk);

        for (int i = 0; i < 5; i++) begin
            send_rx(8'($urandom), ($urandom_range(0, 3) != 0));
            drain();
        end

        tx_send(8'h5A);
        while (tx !== 1'b0) @(negedge clk);
        repeat (64 * 4 + 32) @(negedge clk);
        pulse_reset();
        @(negedge clk);
        check("rst_mid_tx", tx, 1);
        check("rst_mid_tx_status", bus.tx_status, 1);
        repeat (100) @(negedge clk);
        check("rst_mid_tx_idle", tx, 1);
        tx_send(8'h99);
        tx_capture(8'h99);

        f = {1'b1, 8'hC3, 1'b0};
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) begin
            rx_drv = f[i];
            repeat (64) @(posedge clk);
            #1;
        end
        rx_drv = f[4];
        repeat (32) @(posedge clk);
        #1;
        pulse_reset();
        rx_drv = 1'b1;
        repeat (200) @(posedge clk);
        drain();
        send_rx(8'h99, 1'b1);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
